// File: rtl/memtile_cfg_pkg.sv
// Shared types and register map for the LakeTop memory-tile configuration writer.
package memtile_cfg_pkg;

    localparam int CFG_ADDR_W = 8;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_WRITE,
        CFG_READ,
        CFG_RWAIT,
        CFG_FLUSH,
        CFG_DONE
    } cfg_state_t;

    // strg_ub address-generator registers, input (agg) and output (tb) sides.
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_IN_DIMENSIONALITY  = 8'h10;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_IN_STARTING_ADDR   = 8'h11;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_IN_STRIDE          = 8'h12;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_IN_RANGE           = 8'h13;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_OUT_DIMENSIONALITY = 8'h20;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_OUT_STARTING_ADDR  = 8'h21;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_OUT_STRIDE         = 8'h22;
    localparam logic [CFG_ADDR_W-1:0] STRG_UB_OUT_RANGE          = 8'h23;

endpackage

// File: rtl/memtile_cfg_readback_chk.sv
// Readback checker: waits READ_LAT cycles after a config read, compares the
// returned word with the written value and latches the first mismatching address.
module memtile_cfg_readback_chk
    import memtile_cfg_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CFG_ADDR_W-1:0] addr_i,
    input  logic [CFG_DATA_W-1:0] exp_i,
    input  logic [CFG_DATA_W-1:0] rdata_i,
    output logic                  fin_o,
    output logic                  err_o,
    output logic [CFG_ADDR_W-1:0] err_addr_o
);

    localparam int LC_W = $clog2(READ_LAT + 1);

    logic [LC_W-1:0]       lcnt_q, lcnt_d;
    logic                  err_q, err_d;
    logic [CFG_ADDR_W-1:0] err_addr_q, err_addr_d;

    always_comb begin
        lcnt_d     = lcnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        fin_o      = (lcnt_q == LC_W'(1));
        if (start_i) begin
            lcnt_d = LC_W'(READ_LAT);
        end else if (lcnt_q != '0) begin
            lcnt_d = lcnt_q - 1'b1;
        end
        // Only the first mismatch is recorded; later ones leave err_addr alone.
        if (fin_o && (rdata_i != exp_i) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lcnt_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            lcnt_q     <= lcnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: rtl/memtile_config_writer.sv
// Drives host (addr, data) entries onto a memory tile config port, then enables and flushes the tile.
// Define MEMTILE_CFG_READBACK_EN to read back and verify every written register.
module memtile_config_writer
    import memtile_cfg_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int READ_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CFG_ADDR_W-1:0] req_addr,
    input  logic [CFG_DATA_W-1:0] req_data,
    input  logic                  req_last,
    output logic                  config_en,
    output logic                  config_write,
    output logic                  config_read,
    output logic [CFG_ADDR_W-1:0] config_addr_in,
    output logic [CFG_DATA_W-1:0] config_data_in,
    input  logic [CFG_DATA_W-1:0] config_data_out,
    output logic                  tile_en,
    output logic                  flush,
    output logic                  done,
    output logic                  err,
    output logic [CFG_ADDR_W-1:0] err_addr
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    cfg_state_t            state_q, state_d;
    logic [CFG_ADDR_W-1:0] addr_q, addr_d;
    logic [CFG_DATA_W-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [FC_W-1:0]       fcnt_q, fcnt_d;

`ifdef MEMTILE_CFG_READBACK_EN
    logic chk_fin;

    memtile_cfg_readback_chk #(
        .READ_LAT (READ_LAT)
    ) u_chk (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (state_q == CFG_READ),
        .addr_i     (addr_q),
        .exp_i      (data_q),
        .rdata_i    (config_data_out),
        .fin_o      (chk_fin),
        .err_o      (err),
        .err_addr_o (err_addr)
    );

    assign config_read = (state_q == CFG_READ);
`else
    logic unused_readback;
    assign unused_readback = (^config_data_out) ^ (READ_LAT > 0);

    assign config_read = 1'b0;
    assign err         = 1'b0;
    assign err_addr    = '0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            CFG_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    last_d  = req_last;
                    state_d = CFG_WRITE;
                end
            end
            CFG_WRITE: begin
`ifdef MEMTILE_CFG_READBACK_EN
                state_d = CFG_READ;
`else
                if (last_q) begin
                    state_d = CFG_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES);
                end else begin
                    state_d = CFG_IDLE;
                end
`endif
            end
`ifdef MEMTILE_CFG_READBACK_EN
            CFG_READ: begin
                state_d = CFG_RWAIT;
            end
            CFG_RWAIT: begin
                if (chk_fin) begin
                    if (last_q) begin
                        state_d = CFG_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES);
                    end else begin
                        state_d = CFG_IDLE;
                    end
                end
            end
`endif
            CFG_FLUSH: begin
                // Counter holds the flush cycles remaining, including this one.
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q == FC_W'(1)) begin
                    state_d = CFG_DONE;
                end
            end
            CFG_DONE: begin
                state_d = CFG_DONE;
            end
            default: begin
                state_d = CFG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CFG_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign req_ready      = (state_q == CFG_IDLE);
    assign config_en      = (state_q == CFG_WRITE) || (state_q == CFG_READ);
    assign config_write   = (state_q == CFG_WRITE);
    assign config_addr_in = addr_q;
    assign config_data_in = data_q;
    assign flush          = (state_q == CFG_FLUSH);
    assign tile_en        = (state_q == CFG_FLUSH) || (state_q == CFG_DONE);
    assign done           = (state_q == CFG_DONE);

endmodule
